// File: rtl/rename_table.sv
// rename_table: 4-wide dispatch register alias table plus architectural register file.
// Define RENAME_RETIRE_BYPASS_EN to forward same-cycle retire writes into operand reads.
module rename_table (
  input  logic        clk,
  input  logic        rst,
  input  logic        dispatch_valid [4],
  input  logic [3:0]  dest_reg       [4],
  input  logic [3:0]  src_a          [4],
  input  logic [3:0]  src_b          [4],
  input  logic [3:0]  rob_size,
  input  logic        rob_finished   [16],
  input  logic [15:0] rob_values     [16],
  input  logic        ret_we         [4],
  input  logic [3:0]  ret_target     [4],
  input  logic [15:0] ret_data       [4],
  input  logic [3:0]  ret_writer     [4],
  output logic        dispatch_ready,
  output logic        out_valid      [4],
  output logic [3:0]  out_tag        [4],
  output logic        out_a_ready    [4],
  output logic        out_b_ready    [4],
  output logic [15:0] out_a_val      [4],
  output logic [15:0] out_b_val      [4],
  output logic [3:0]  out_a_tag      [4],
  output logic [3:0]  out_b_tag      [4]
);

  logic [15:0] regs_q [16];
  logic [15:0] regs_d [16];
  logic [15:0] busy_q, busy_d;
  logic [3:0]  tag_q  [16];
  logic [3:0]  tag_d  [16];
  logic [3:0]  head_q, head_d;

  logic        out_valid_q   [4];
  logic        out_valid_d   [4];
  logic [3:0]  out_tag_q     [4];
  logic [3:0]  out_tag_d     [4];
  logic        out_a_ready_q [4];
  logic        out_a_ready_d [4];
  logic        out_b_ready_q [4];
  logic        out_b_ready_d [4];
  logic [15:0] out_a_val_q   [4];
  logic [15:0] out_a_val_d   [4];
  logic [15:0] out_b_val_q   [4];
  logic [15:0] out_b_val_d   [4];
  logic [3:0]  out_a_tag_q   [4];
  logic [3:0]  out_a_tag_d   [4];
  logic [3:0]  out_b_tag_q   [4];
  logic [3:0]  out_b_tag_d   [4];

  logic [2:0]        count;
  logic [7:0]        res_rdy;
  logic [7:0][15:0]  res_val;
  logic [7:0][3:0]   res_tag;

  always_comb begin
    count = '0;
    for (int i = 0; i < 4; i++) begin
      count = count + {2'b00, dispatch_valid[i]};
    end
  end

  assign dispatch_ready = ({1'b0, rob_size} + {2'b00, count}) <= 5'd15;

  // Operands 0..3 are src_a of slots 0..3, operands 4..7 are src_b of slots 0..3.
  for (genvar gi = 0; gi < 8; gi++) begin : g_op
    localparam int SLOT = gi % 4;
    logic [3:0]  src_sel;
    logic [3:0]  cur_tag;
    logic        rdy;
    logic [15:0] val;
    logic [3:0]  tg;

    if (gi < 4) begin : g_a
      assign src_sel = src_a[SLOT];
    end else begin : g_b
      assign src_sel = src_b[SLOT];
    end

    assign cur_tag = tag_q[src_sel];

    always_comb begin
      rdy = 1'b1;
      val = regs_q[src_sel];
      tg  = '0;
      if (busy_q[src_sel]) begin
        if (rob_finished[cur_tag]) begin
          val = rob_values[cur_tag];
        end else begin
          rdy = 1'b0;
          tg  = cur_tag;
`ifdef RENAME_RETIRE_BYPASS_EN
          for (int k = 0; k < 4; k++) begin
            if (ret_we[k] && ret_writer[k] == cur_tag) begin
              rdy = 1'b1;
              val = ret_data[k];
            end
          end
`endif
        end
      end
`ifdef RENAME_RETIRE_BYPASS_EN
      else begin
        for (int k = 0; k < 4; k++) begin
          if (ret_we[k] && ret_target[k] == src_sel) val = ret_data[k];
        end
      end
`endif
      // Older slots in the same group override the table; later j wins.
      for (int j = 0; j < SLOT; j++) begin
        if (dest_reg[j] == src_sel) begin
          rdy = 1'b0;
          tg  = head_q + 4'(j);
        end
      end
    end

    assign res_rdy[gi] = rdy;
    assign res_val[gi] = val;
    assign res_tag[gi] = tg;
  end

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      out_valid_d[i]   = dispatch_valid[i] && dispatch_ready;
      out_tag_d[i]     = head_q + 4'(i);
      out_a_ready_d[i] = res_rdy[i];
      out_a_val_d[i]   = res_val[i];
      out_a_tag_d[i]   = res_tag[i];
      out_b_ready_d[i] = res_rdy[i+4];
      out_b_val_d[i]   = res_val[i+4];
      out_b_tag_d[i]   = res_tag[i+4];
    end
  end

  // Retire is applied before rename so a same-cycle rename of the register keeps it busy.
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    tag_d  = tag_q;
    head_d = head_q;
    for (int k = 0; k < 4; k++) begin
      if (ret_we[k]) begin
        regs_d[ret_target[k]] = ret_data[k];
        if (tag_q[ret_target[k]] == ret_writer[k]) busy_d[ret_target[k]] = 1'b0;
      end
    end
    if (dispatch_ready) begin
      for (int i = 0; i < 4; i++) begin
        if (dispatch_valid[i]) begin
          busy_d[dest_reg[i]] = 1'b1;
          tag_d[dest_reg[i]]  = head_q + 4'(i);
        end
      end
      head_d = head_q + {1'b0, count};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
      head_q <= '0;
      for (int r = 0; r < 16; r++) begin
        regs_q[r] <= '0;
        tag_q[r]  <= '0;
      end
      for (int i = 0; i < 4; i++) begin
        out_valid_q[i]   <= 1'b0;
        out_tag_q[i]     <= '0;
        out_a_ready_q[i] <= 1'b0;
        out_a_val_q[i]   <= '0;
        out_a_tag_q[i]   <= '0;
        out_b_ready_q[i] <= 1'b0;
        out_b_val_q[i]   <= '0;
        out_b_tag_q[i]   <= '0;
      end
    end else begin
      busy_q        <= busy_d;
      head_q        <= head_d;
      regs_q        <= regs_d;
      tag_q         <= tag_d;
      out_valid_q   <= out_valid_d;
      out_tag_q     <= out_tag_d;
      out_a_ready_q <= out_a_ready_d;
      out_a_val_q   <= out_a_val_d;
      out_a_tag_q   <= out_a_tag_d;
      out_b_ready_q <= out_b_ready_d;
      out_b_val_q   <= out_b_val_d;
      out_b_tag_q   <= out_b_tag_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_tag     = out_tag_q;
  assign out_a_ready = out_a_ready_q;
  assign out_a_val   = out_a_val_q;
  assign out_a_tag   = out_a_tag_q;
  assign out_b_ready = out_b_ready_q;
  assign out_b_val   = out_b_val_q;
  assign out_b_tag   = out_b_tag_q;

endmodule

// File: tb/tb_rename_table.sv
// Directed bench for rename_table with a behavioural alias-table model and literal spot checks.
module tb_rename_table;

  logic        clk = 1'b0;
  logic        rst;
  logic        dispatch_valid [4];
  logic [3:0]  dest_reg       [4];
  logic [3:0]  src_a          [4];
  logic [3:0]  src_b          [4];
  logic [3:0]  rob_size;
  logic        rob_finished   [16];
  logic [15:0] rob_values     [16];
  logic        ret_we         [4];
  logic [3:0]  ret_target     [4];
  logic [15:0] ret_data       [4];
  logic [3:0]  ret_writer     [4];
  logic        dispatch_ready;
  logic        out_valid      [4];
  logic [3:0]  out_tag        [4];
  logic        out_a_ready    [4];
  logic        out_b_ready    [4];
  logic [15:0] out_a_val      [4];
  logic [15:0] out_b_val      [4];
  logic [3:0]  out_a_tag      [4];
  logic [3:0]  out_b_tag      [4];

  always #5 clk = ~clk;

  rename_table dut (
    .clk(clk), .rst(rst),
    .dispatch_valid(dispatch_valid), .dest_reg(dest_reg), .src_a(src_a), .src_b(src_b),
    .rob_size(rob_size), .rob_finished(rob_finished), .rob_values(rob_values),
    .ret_we(ret_we), .ret_target(ret_target), .ret_data(ret_data), .ret_writer(ret_writer),
    .dispatch_ready(dispatch_ready), .out_valid(out_valid), .out_tag(out_tag),
    .out_a_ready(out_a_ready), .out_b_ready(out_b_ready),
    .out_a_val(out_a_val), .out_b_val(out_b_val),
    .out_a_tag(out_a_tag), .out_b_tag(out_b_tag)
  );

  // Model state: what the architectural table must hold.
  int m_regs [16];
  bit m_busy [16];
  int m_tag  [16];
  int m_head;

  bit e_full;
  bit e_ready;
  bit e_valid [4];
  int e_tag   [4];
  bit e_ar [4], e_br [4];
  int e_av [4], e_bv [4], e_at [4], e_bt [4];
  bit last_ready;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Resolve source s for slot i in the priority order of the rename rules.
  function automatic void resolve(input int i, input int s, output bit r, output int v, output int t);
    r = 0; v = 0; t = 0;
    for (int j = i - 1; j >= 0; j--) begin
      if (int'(dest_reg[j]) == s) begin
        t = (m_head + j) % 16;
        return;
      end
    end
    if (m_busy[s]) begin
      if (rob_finished[m_tag[s]]) begin
        r = 1; v = int'(rob_values[m_tag[s]]);
        return;
      end
`ifdef RENAME_RETIRE_BYPASS_EN
      for (int k = 3; k >= 0; k--) begin
        if (ret_we[k] && int'(ret_writer[k]) == m_tag[s]) begin
          r = 1; v = int'(ret_data[k]);
          return;
        end
      end
`endif
      t = m_tag[s];
      return;
    end
    r = 1; v = m_regs[s];
`ifdef RENAME_RETIRE_BYPASS_EN
    for (int k = 0; k < 4; k++) begin
      if (ret_we[k] && int'(ret_target[k]) == s) v = int'(ret_data[k]);
    end
`endif
  endfunction

  task automatic model_step();
    int cnt;
    int old_tag [16];
    cnt = 0;
    for (int i = 0; i < 4; i++) if (dispatch_valid[i]) cnt++;
    e_ready = (int'(rob_size) + cnt) <= 15;
    if (rst) begin
      e_full = 1;
      m_head = 0;
      for (int r = 0; r < 16; r++) begin
        m_regs[r] = 0; m_busy[r] = 0; m_tag[r] = 0;
      end
      for (int i = 0; i < 4; i++) begin
        e_valid[i] = 0; e_tag[i] = 0;
        e_ar[i] = 0; e_br[i] = 0; e_av[i] = 0; e_bv[i] = 0; e_at[i] = 0; e_bt[i] = 0;
      end
      return;
    end
    e_full = 0;
    for (int i = 0; i < 4; i++) begin
      e_valid[i] = dispatch_valid[i] && e_ready;
      e_tag[i]   = (m_head + i) % 16;
      resolve(i, int'(src_a[i]), e_ar[i], e_av[i], e_at[i]);
      resolve(i, int'(src_b[i]), e_br[i], e_bv[i], e_bt[i]);
    end
    old_tag = m_tag;
    for (int k = 0; k < 4; k++) begin
      if (ret_we[k]) begin
        m_regs[ret_target[k]] = int'(ret_data[k]);
        if (old_tag[ret_target[k]] == int'(ret_writer[k])) m_busy[ret_target[k]] = 0;
      end
    end
    if (e_ready) begin
      for (int i = 0; i < 4; i++) begin
        if (dispatch_valid[i]) begin
          m_busy[dest_reg[i]] = 1;
          m_tag[dest_reg[i]]  = (m_head + i) % 16;
        end
      end
      m_head = (m_head + cnt) % 16;
    end
  endtask

  task automatic compare();
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("out_valid[%0d]", i), int'(out_valid[i]), int'(e_valid[i]));
      if (e_valid[i] || e_full) begin
        chk($sformatf("out_tag[%0d]", i), int'(out_tag[i]), e_tag[i]);
        chk($sformatf("out_a_ready[%0d]", i), int'(out_a_ready[i]), int'(e_ar[i]));
        chk($sformatf("out_b_ready[%0d]", i), int'(out_b_ready[i]), int'(e_br[i]));
        if (e_ar[i] || e_full) chk($sformatf("out_a_val[%0d]", i), int'(out_a_val[i]), e_av[i]);
        if (!e_ar[i] || e_full) chk($sformatf("out_a_tag[%0d]", i), int'(out_a_tag[i]), e_at[i]);
        if (e_br[i] || e_full) chk($sformatf("out_b_val[%0d]", i), int'(out_b_val[i]), e_bv[i]);
        if (!e_br[i] || e_full) chk($sformatf("out_b_tag[%0d]", i), int'(out_b_tag[i]), e_bt[i]);
      end
    end
  endtask

  task automatic step(input string label);
    #1;
    model_step();
    last_ready = dispatch_ready;
    chk("dispatch_ready", int'(dispatch_ready), int'(e_ready));
    @(posedge clk);
    #1;
    cyc++;
    compare();
    $display("cyc %0d %s: ready=%0d valid=%0d%0d%0d%0d tags=%0d,%0d,%0d,%0d head=%0d",
             cyc, label, last_ready, out_valid[0], out_valid[1], out_valid[2], out_valid[3],
             out_tag[0], out_tag[1], out_tag[2], out_tag[3], m_head);
  endtask

  task automatic clear_inputs();
    rob_size = '0;
    for (int i = 0; i < 4; i++) begin
      dispatch_valid[i] = 1'b0; dest_reg[i] = '0; src_a[i] = '0; src_b[i] = '0;
      ret_we[i] = 1'b0; ret_target[i] = '0; ret_data[i] = '0; ret_writer[i] = '0;
    end
    for (int e = 0; e < 16; e++) begin
      rob_finished[e] = 1'b0; rob_values[e] = '0;
    end
  endtask

  initial begin
    clear_inputs();
    rst = 1'b1;
    step("reset");
    chk("reset out_valid0", int'(out_valid[0]), 0);
    chk("reset a_ready0", int'(out_a_ready[0]), 0);
    rst = 1'b0;

    clear_inputs();
    dispatch_valid[0] = 1; src_a[0] = 3; dest_reg[0] = 1;
    step("single");
    chk("t1 a_ready", int'(out_a_ready[0]), 1);
    chk("t1 a_val", int'(out_a_val[0]), 0);
    chk("t1 tag", int'(out_tag[0]), 0);
    chk("t1 head", m_head, 1);

    clear_inputs();
    rob_size = 1;
    for (int i = 0; i < 4; i++) begin
      dispatch_valid[i] = 1; dest_reg[i] = 4'(5 + i);
    end
    src_b[2] = 5;
    step("group4");
    chk("t2 b_ready2", int'(out_b_ready[2]), 0);
    chk("t2 b_tag2", int'(out_b_tag[2]), 1);
    chk("t2 tag3", int'(out_tag[3]), 4);

    clear_inputs();
    dispatch_valid[0] = 1; src_a[0] = 5; dest_reg[0] = 9;
    step("read r5");
    chk("t2b a_ready", int'(out_a_ready[0]), 0);
    chk("t2b a_tag", int'(out_a_tag[0]), 1);
    chk("t2b tag", int'(out_tag[0]), 5);

    clear_inputs();
    rob_size = 13;
    for (int i = 0; i < 3; i++) begin
      dispatch_valid[i] = 1; dest_reg[i] = 4'(10 + i);
    end
    step("full reject");
    chk("t3 ready", int'(last_ready), 0);
    chk("t3 valid0", int'(out_valid[0]), 0);
    chk("t3 head", m_head, 6);

    dispatch_valid[2] = 0;
    step("fits 2");
    chk("t3b ready", int'(last_ready), 1);
    chk("t3b tag0", int'(out_tag[0]), 6);
    chk("t3b tag1", int'(out_tag[1]), 7);

    clear_inputs();
    rob_size = 15;
    step("size15 empty");
    chk("t3c ready", int'(last_ready), 1);
    dispatch_valid[0] = 1;
    step("size15 one");
    chk("t3d ready", int'(last_ready), 0);

    clear_inputs();
    dispatch_valid[0] = 1; dest_reg[0] = 0;
    dispatch_valid[1] = 1; dest_reg[1] = 7;
    step("r7 tag9");
    chk("t4 tag1", int'(out_tag[1]), 9);

    clear_inputs();
    dispatch_valid[0] = 1; src_a[0] = 7; dest_reg[0] = 2;
    rob_finished[9] = 1; rob_values[9] = 16'h1234;
    step("rob fwd");
    chk("t4b a_ready", int'(out_a_ready[0]), 1);
    chk("t4b a_val", int'(out_a_val[0]), 'h1234);

    clear_inputs();
    dispatch_valid[0] = 1; dest_reg[0] = 7;
    ret_we[0] = 1; ret_target[0] = 7; ret_data[0] = 16'h5555; ret_writer[0] = 9;
    step("retire+rename");
    chk("t5 tag", int'(out_tag[0]), 11);
    chk("t5 model regs7", m_regs[7], 'h5555);

    clear_inputs();
    dispatch_valid[0] = 1; src_a[0] = 7; dest_reg[0] = 3;
    step("r7 still busy");
    chk("t5b a_ready", int'(out_a_ready[0]), 0);
    chk("t5b a_tag", int'(out_a_tag[0]), 11);

    clear_inputs();
    ret_we[0] = 1; ret_target[0] = 7; ret_data[0] = 16'h1111; ret_writer[0] = 0;
    ret_we[2] = 1; ret_target[2] = 7; ret_data[2] = 16'hBEEF; ret_writer[2] = 11;
    step("dual retire");

    clear_inputs();
    dispatch_valid[0] = 1; src_a[0] = 7; src_b[0] = 1; dest_reg[0] = 4;
    step("read r7 r1");
    chk("t5d a_ready", int'(out_a_ready[0]), 1);
    chk("t5d a_val", int'(out_a_val[0]), 'hBEEF);
    chk("t5d b_ready", int'(out_b_ready[0]), 0);
    chk("t5d b_tag", int'(out_b_tag[0]), 0);
    chk("t5d head", m_head, 14);

    clear_inputs();
    for (int i = 0; i < 4; i++) dispatch_valid[i] = 1;
    dest_reg[0] = 12; dest_reg[1] = 12; dest_reg[2] = 14; dest_reg[3] = 15;
    src_a[3] = 12;
    step("wrap");
    chk("t6 tag0", int'(out_tag[0]), 14);
    chk("t6 tag1", int'(out_tag[1]), 15);
    chk("t6 tag2", int'(out_tag[2]), 0);
    chk("t6 tag3", int'(out_tag[3]), 1);
    chk("t6 a_tag3", int'(out_a_tag[3]), 15);
    chk("t6 head", m_head, 2);

    clear_inputs();
    dispatch_valid[0] = 1; src_a[0] = 12; dest_reg[0] = 5;
    step("read r12");
    chk("t6b a_tag", int'(out_a_tag[0]), 15);
    chk("t6b tag", int'(out_tag[0]), 2);

    clear_inputs();
    dispatch_valid[0] = 1; dest_reg[0] = 6;
    ret_we[0] = 1; ret_target[0] = 3; ret_data[0] = 16'h0077;
    rst = 1'b1;
    step("mid reset");
    chk("t7 valid0", int'(out_valid[0]), 0);
    rst = 1'b0;

    clear_inputs();
    dispatch_valid[0] = 1; src_a[0] = 3; dest_reg[0] = 1;
    step("after reset");
    chk("t7b tag", int'(out_tag[0]), 0);
    chk("t7b a_ready", int'(out_a_ready[0]), 1);
    chk("t7b a_val", int'(out_a_val[0]), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/rename_table.md
# rename_table

Dispatch-side register alias table and architectural register file, directly upstream of the 16-entry reorder buffer. Each cycle it accepts up to four decoded instructions, allocates consecutive ROB indices, and resolves each source operand to a value or a ROB tag. It also consumes the ROB's four retire write ports to update architectural state.

## Interface
- No parameters. Widths are fixed: 16 architectural registers, 16-bit data, 16 ROB entries, 4-wide.
- `clk` in 1: single clock. All state changes on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `dispatch_valid[0:3]` in 1 each: slot valid. Valid slots are contiguous from slot 0.
- `dest_reg[0:3]` in 4 each: destination architectural register.
- `src_a[0:3]`, `src_b[0:3]` in 4 each: source architectural registers.
- `rob_size` in 4: current ROB occupancy.
- `rob_finished[0:15]` in 1 each: per-entry ROB finished flag.
- `rob_values[0:15]` in 16 each: per-entry ROB result value.
- `ret_we[0:3]` in 1 each: retire write enable.
- `ret_target[0:3]` in 4 each: retire destination register.
- `ret_data[0:3]` in 16 each: retire write data.
- `ret_writer[0:3]` in 4 each: ROB index of the retiring instruction.
- `dispatch_ready` out 1: combinational. High when the current group fits in the ROB.
- `out_valid[0:3]` out 1 each: registered renamed-slot valid.
- `out_tag[0:3]` out 4 each: ROB index allocated to the slot. Connects to ROB `new_targets` / the allocation path.
- `out_a_ready[0:3]`, `out_b_ready[0:3]` out 1 each: operand value is available.
- `out_a_val[0:3]`, `out_b_val[0:3]` out 16 each: operand value. Meaningful when the matching ready flag is 1.
- `out_a_tag[0:3]`, `out_b_tag[0:3]` out 4 each: producing ROB index. Meaningful when the matching ready flag is 0.

## Operation
- State:
  - `regs[0:15]` (16 bits each)
  - `busy[0:15]`
  - `tag[0:15]` (4 bits each)
  - `head` (4 bits)
- Group size:
  - count = number of valid slots, 0–4.
  - `dispatch_ready` = (`rob_size` + count ≤ 15). Evaluate in 5-bit arithmetic.
  - When not ready, the whole group is rejected. No partial acceptance. No state change except retire.
- Tag allocation: accepted slot i receives `out_tag[i]` = `head` + i, modulo 16. `head` advances by count and wraps naturally.
- Source resolution for slot i, source s, in priority order:
  1. Some earlier slot j < i in the same group has `dest_reg[j]` == s: not ready, tag = `head` + j. Use the highest such j.
  2. `busy[s]` set and `rob_finished[tag[s]]`: ready, value = `rob_values[tag[s]]`.
  3. `busy[s]` set: not ready, tag = `tag[s]`.
  4. Otherwise: ready, value = `regs[s]`, with the retire bypass (see Configuration).
- Rename update: for each accepted slot, set `busy[dest]` and `tag[dest]` = slot tag. When two slots share a destination, the higher slot wins.
- Retire, for each k with `ret_we[k]`:
  - `regs[ret_target[k]]` ← `ret_data[k]`.
  - `busy` clears only if `tag[ret_target[k]]` == `ret_writer[k]` and the same register is not renamed this cycle. Rename wins.
  - Same target on two retire ports: higher k wins.
- Retire is processed regardless of `dispatch_ready`.

## Timing
- Rename latency: one cycle. Inputs sampled at edge N drive `out_*` after edge N; outputs hold for one cycle.
- `out_valid[i]` = `dispatch_valid[i]` && `dispatch_ready` at the sampling edge. Otherwise 0.
- Retire writes are visible to table reads in the following cycle. Same-cycle visibility depends only on the bypass.
- Reset values:
  - All `regs` = 0; all `busy` = 0; all `tag` = 0; `head` = 0.
  - All `out_valid` = 0.
  - All `out_*_ready` = 0; all `out_*_val` = 0; all `out_*_tag` = 0; all `out_tag` = 0.
- Reset asserted mid-operation discards the in-flight group. Reset overrides retire and rename in the same cycle.
- `head` wrap 15→0 and allocation across the wrap (e.g. head 14, count 4 → tags 14, 15, 0, 1) are legal.

## Configuration
- `RENAME_RETIRE_BYPASS_EN` defined:
  - Case 4 sources also compare against same-cycle retire ports.
  - If `ret_we[k]` and `ret_target[k]` == s, the value is `ret_data[k]`. Highest k wins.
  - Case 3 with `ret_writer[k]` == `tag[s]` also resolves ready with `ret_data[k]`.
- Not defined: no same-cycle retire comparison. Operands see pre-edge `regs`/`busy`/`tag` only.

## Test plan
- Reset, then slot0 `src_a`=3 → `out_a_ready`=1, `out_a_val`=0, `out_tag[0]`=0, `head`=1.
- Group of 4 with dest r5 in slot0 and `src_b`=5 in slot2 → slot2 `out_b_ready`=0, `out_b_tag`=`head`+0. Next cycle r5 reads busy with tag `head`+0.
- `rob_size`=13 and count=3 → `dispatch_ready`=0, all `out_valid`=0, `head` unchanged. With count=2, accepted.
- r7 busy with tag 9, `rob_finished[9]`=1, `rob_values[9]`=0x1234 → source r7 ready with 0x1234.
- Retire r7 writer 9 in the same cycle slot0 renames r7 → `busy[7]` stays 1, `tag[7]` = new tag, `regs[7]` updated.
- `head`=14, four valid → tags 14, 15, 0, 1; `head`=2 afterwards.
